// File: rtl/iperf_client_hls_deadlock_report_unit.sv
// Deadlock report unit: latches the first-detecting process, traces the token ring, and holds a report until acknowledged.
// Latency: detection -> origin pulse 1 cycle; token_clear is combinational in the return/timeout cycle; report is visible the cycle after.
// Backpressure: a report is held in DONE until report_ack; new detections are ignored until the FSM is back in IDLE.
// Optional: define IPERF_CLIENT_DL_TRACE_TIMEOUT_EN to end a trace after TIMEOUT cycles without return to origin.
module iperf_client_hls_deadlock_report_unit #(
    parameter int PROC_NUM = 4,
    parameter int ID_W     = 2,
    parameter int TIMEOUT  = 1023
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_detect_vec,
    input  logic [PROC_NUM-1:0] token_ret_vec,
    input  logic                report_ack,
    output logic                dl_detect_in,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic                token_clear,
    output logic                dl_valid,
    output logic [ID_W-1:0]     dl_first_id,
    output logic [PROC_NUM-1:0] dl_proc_vec,
    output logic                dl_timeout,
    output logic [7:0]          dl_report_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ORIGIN = 2'd1,
        S_TRACE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_nxt;
    logic [ID_W-1:0]     first_id_q;
    logic [PROC_NUM-1:0] proc_vec_q;
    logic                timeout_q;
    logic [7:0]          report_cnt_q;

    logic [ID_W-1:0]     low_id;
    logic [PROC_NUM-1:0] origin_onehot;
    logic                origin_hit;
    logic                timeout_hit;
    logic                origin_pulse;
    logic                clear_pulse;

    // Lowest-index set detection bit picks the origin process.
    always_comb begin
        low_id = '0;
        for (int p = PROC_NUM - 1; p >= 0; p--) begin
            if (dl_detect_vec[p]) begin
                low_id = ID_W'(p);
            end
        end
    end

    assign origin_onehot = PROC_NUM'(1) << first_id_q;
    assign origin_hit    = dl_detect_vec[first_id_q];

`ifdef IPERF_CLIENT_DL_TRACE_TIMEOUT_EN
    logic [15:0] trace_cnt_q;

    assign timeout_hit = (state_q == S_TRACE) && (trace_cnt_q == 16'(TIMEOUT - 1));

    // Trace counter: cleared at the origin pulse, counts every TRACE cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            trace_cnt_q <= '0;
        end else if (state_q == S_ORIGIN) begin
            trace_cnt_q <= '0;
        end else if (state_q == S_TRACE) begin
            trace_cnt_q <= trace_cnt_q + 16'd1;
        end
    end

    // Report ending cause: return to origin beats a coincident timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else if (state_q == S_TRACE) begin
            if (origin_hit) begin
                timeout_q <= 1'b0;
            end else if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_q   = 1'b0;
`endif

    // Next-state and single-cycle pulse decode.
    always_comb begin
        state_nxt    = state_q;
        origin_pulse = 1'b0;
        clear_pulse  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|dl_detect_vec) begin
                    state_nxt = S_ORIGIN;
                end
            end
            S_ORIGIN: begin
                origin_pulse = 1'b1;
                state_nxt    = S_TRACE;
            end
            S_TRACE: begin
                if (origin_hit || timeout_hit) begin
                    clear_pulse = 1'b1;
                    state_nxt   = S_DONE;
                end
            end
            S_DONE: begin
                if (report_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, origin id, dependency-cycle vector and accepted-report counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            first_id_q   <= '0;
            proc_vec_q   <= '0;
            report_cnt_q <= '0;
        end else begin
            state_q <= state_nxt;
            case (state_q)
                S_IDLE: begin
                    if (|dl_detect_vec) begin
                        first_id_q <= low_id;
                    end
                end
                S_ORIGIN: proc_vec_q <= origin_onehot;
                S_TRACE:  proc_vec_q <= proc_vec_q | token_ret_vec;
                S_DONE: begin
                    if (report_ack && (report_cnt_q != 8'hFF)) begin
                        report_cnt_q <= report_cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Everything reads zero while reset is held, so an aborted trace never leaks a clear pulse.
    assign dl_detect_in  = !reset && (state_q != S_IDLE);
    assign origin_vec    = (!reset && origin_pulse) ? origin_onehot : '0;
    assign token_clear   = !reset && clear_pulse;
    assign dl_valid      = !reset && (state_q == S_DONE);
    assign dl_first_id   = reset ? '0 : first_id_q;
    assign dl_proc_vec   = reset ? '0 : proc_vec_q;
    assign dl_timeout    = !reset && timeout_q;
    assign dl_report_cnt = reset ? 8'd0 : report_cnt_q;

endmodule

// File: tb/tb_iperf_client_hls_deadlock_report_unit.sv
// Bench for the deadlock report unit: vector table over one full report plus reset abort, then directed sequences.
// Latency: inputs driven 1ns after posedge, outputs compared on the following negedge.
// Backpressure: report_ack is driven directly by the stimulus.
module tb_iperf_client_hls_deadlock_report_unit;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] dl_detect_vec = '0;
    logic [3:0] token_ret_vec = '0;
    logic       report_ack = 1'b0;
    logic       dl_detect_in;
    logic [3:0] origin_vec;
    logic       token_clear;
    logic       dl_valid;
    logic [1:0] dl_first_id;
    logic [3:0] dl_proc_vec;
    logic       dl_timeout;
    logic [7:0] dl_report_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    iperf_client_hls_deadlock_report_unit #(
        .PROC_NUM(4),
        .ID_W(2),
        .TIMEOUT(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .dl_detect_vec(dl_detect_vec),
        .token_ret_vec(token_ret_vec),
        .report_ack(report_ack),
        .dl_detect_in(dl_detect_in),
        .origin_vec(origin_vec),
        .token_clear(token_clear),
        .dl_valid(dl_valid),
        .dl_first_id(dl_first_id),
        .dl_proc_vec(dl_proc_vec),
        .dl_timeout(dl_timeout),
        .dl_report_cnt(dl_report_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [3:0] det;
        logic [3:0] ret;
        logic       ack;
        logic       e_din;
        logic [3:0] e_org;
        logic       e_clr;
        logic       e_vld;
        logic [1:0] e_id;
        logic [3:0] e_proc;
        logic       e_to;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] det, input logic [3:0] ret, input logic ack);
        @(posedge clock);
        #1;
        reset = rst;
        dl_detect_vec = det;
        token_ret_vec = ret;
        report_ack = ack;
        @(negedge clock);
    endtask

    // One complete report on process id: detect, origin, immediate return, ack.
    task automatic quick_report(input logic [3:0] det);
        step(1'b0, det, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, det, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b1);
        if (exp_cnt < 255) exp_cnt++;
    endtask

    initial begin
        //          rst  det      ret      ack  din  org      clr  vld  id  proc     to   cnt
        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 4'b0110, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'd0};
        tbl[2]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'd0};
        tbl[3]  = '{1'b0, 4'b0110, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'd0};
        tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 8'd0};
        tbl[5]  = '{1'b0, 4'b0000, 4'b0100, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd1, 4'b0010, 1'b0, 8'd0};
        tbl[6]  = '{1'b0, 4'b0001, 4'b1000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd1, 4'b0110, 1'b0, 8'd0};
        tbl[7]  = '{1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd1, 4'b1110, 1'b0, 8'd0};
        tbl[8]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b1110, 1'b0, 8'd0};
        tbl[9]  = '{1'b0, 4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b1110, 1'b0, 8'd0};
        tbl[10] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b1110, 1'b0, 8'd0};
        tbl[11] = '{1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b1110, 1'b0, 8'd0};
        tbl[12] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b1110, 1'b0, 8'd0};
        tbl[13] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b1110, 1'b0, 8'd0};
        tbl[14] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1, 4'b1110, 1'b0, 8'd1};
        tbl[15] = '{1'b0, 4'b1000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1, 4'b1110, 1'b0, 8'd1};
        tbl[16] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 2'd3, 4'b1110, 1'b0, 8'd1};
        tbl[17] = '{1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd3, 4'b1000, 1'b0, 8'd1};
        tbl[18] = '{1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'd0};
        tbl[19] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'd0};

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].rst, tbl[i].det, tbl[i].ret, tbl[i].ack);
            chk("dl_detect_in", i, 32'(dl_detect_in), 32'(tbl[i].e_din));
            chk("origin_vec", i, 32'(origin_vec), 32'(tbl[i].e_org));
            chk("token_clear", i, 32'(token_clear), 32'(tbl[i].e_clr));
            chk("dl_valid", i, 32'(dl_valid), 32'(tbl[i].e_vld));
            chk("dl_first_id", i, 32'(dl_first_id), 32'(tbl[i].e_id));
            chk("dl_proc_vec", i, 32'(dl_proc_vec), 32'(tbl[i].e_proc));
            chk("dl_timeout", i, 32'(dl_timeout), 32'(tbl[i].e_to));
            chk("dl_report_cnt", i, 32'(dl_report_cnt), 32'(tbl[i].e_cnt));
        end
        exp_cnt = 0;

        // Lowest set index wins when several processes detect together.
        step(1'b0, 4'b1100, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        chk("multi_first_id", 0, 32'(dl_first_id), 32'd2);
        chk("multi_origin", 0, 32'(origin_vec), 32'h4);
        step(1'b0, 4'b0100, 4'b0000, 1'b0);
        chk("multi_clear", 0, 32'(token_clear), 32'd1);
        step(1'b0, 4'b0000, 4'b0000, 1'b1);
        chk("multi_proc", 0, 32'(dl_proc_vec), 32'h4);
        exp_cnt++;
        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        chk("multi_cnt", 0, 32'(dl_report_cnt), 32'(exp_cnt));

`ifdef IPERF_CLIENT_DL_TRACE_TIMEOUT_EN
        // Timeout: clear fires on the 8th TRACE cycle after ORIGIN.
        step(1'b0, 4'b0001, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        chk("to_origin", 0, 32'(origin_vec), 32'h1);
        for (int c = 1; c <= 8; c++) begin
            step(1'b0, 4'b0000, 4'b0000, 1'b0);
            chk("to_clear", c, 32'(token_clear), (c == 8) ? 32'd1 : 32'd0);
        end
        step(1'b0, 4'b0000, 4'b0000, 1'b1);
        chk("to_valid", 0, 32'(dl_valid), 32'd1);
        chk("to_timeout", 0, 32'(dl_timeout), 32'd1);
        exp_cnt++;
        // Return to origin coinciding with timeout is reported as a return.
        step(1'b0, 4'b0001, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            step(1'b0, (c == 8) ? 4'b0001 : 4'b0000, 4'b0000, 1'b0);
            chk("tie_clear", c, 32'(token_clear), (c == 8) ? 32'd1 : 32'd0);
        end
        step(1'b0, 4'b0000, 4'b0000, 1'b1);
        chk("tie_timeout", 0, 32'(dl_timeout), 32'd0);
        chk("tie_valid", 0, 32'(dl_valid), 32'd1);
        exp_cnt++;
`else
        // No timeout logic: TRACE holds for 1000 cycles without a clear.
        begin
            int bad_cycles;
            bad_cycles = 0;
            step(1'b0, 4'b0001, 4'b0000, 1'b0);
            step(1'b0, 4'b0000, 4'b0000, 1'b0);
            for (int c = 0; c < 1000; c++) begin
                step(1'b0, 4'b0000, 4'b0000, 1'b1);
                if (token_clear !== 1'b0 || dl_valid !== 1'b0 || dl_detect_in !== 1'b1) bad_cycles++;
            end
            chk("hold_trace_bad_cycles", 0, 32'(bad_cycles), 32'd0);
            step(1'b0, 4'b0001, 4'b0000, 1'b0);
            chk("hold_clear", 0, 32'(token_clear), 32'd1);
            step(1'b0, 4'b0000, 4'b0000, 1'b1);
            chk("hold_timeout", 0, 32'(dl_timeout), 32'd0);
            exp_cnt++;
        end
`endif

        // Saturation of the accepted-report counter.
        while (exp_cnt < 255) quick_report(4'b0001);
        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        chk("cnt_255", 0, 32'(dl_report_cnt), 32'd255);
        quick_report(4'b0010);
        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        chk("cnt_sat", 0, 32'(dl_report_cnt), 32'd255);
        chk("cnt_idle_din", 0, 32'(dl_detect_in), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
